// File: rtl/led_display_frame_reader.sv
// Row source for the LED panel PHY: scans a double-banked frame RAM column by column,
// assembles one top/bottom row pair and presents it on a valid/ready handshake.
package led_display_pkg;
    localparam int LED_COLS = 64;

    typedef struct packed {
        logic [LED_COLS-1:0] b;
        logic [LED_COLS-1:0] g;
        logic [LED_COLS-1:0] r;
    } rgb_vec_t;

    typedef struct packed {
        rgb_vec_t bot;
        rgb_vec_t top;
    } rgb_row_t;
endpackage

module led_display_frame_reader
    import led_display_pkg::*;
#(
    parameter int NUM_COLS     = LED_COLS,
    parameter int NUM_ROW_ADDR = 16
) (
    input  logic                                                 clk_in,
    input  logic                                                 reset_in,
    input  logic                                                 enable_in,
    input  logic                                                 bank_sel_in,
    output logic [$clog2(NUM_ROW_ADDR)+$clog2(NUM_COLS):0]       mem_addr_out,
    output logic                                                 mem_rd_en_out,
    input  logic [5:0]                                           mem_data_in,
    output rgb_row_t                                             row_out,
    output logic                                                 row_valid_out,
    input  logic                                                 row_ready_in,
    output logic [$clog2(NUM_ROW_ADDR)-1:0]                      row_address_out,
    output logic                                                 frame_done_out
);
    localparam int CW = $clog2(NUM_COLS);
    localparam int RW = $clog2(NUM_ROW_ADDR);

    typedef enum logic [1:0] {IDLE, FILL, LAST, HOLD} state_t;

    state_t          state_q;
    logic            bank_q;
    logic [RW-1:0]   fill_row_q;
    logic [CW-1:0]   col_q;
    logic            rd_en_q;
    logic            cap_en_q;
    logic [CW-1:0]   cap_col_q;
    rgb_row_t        fill_q;
    rgb_row_t        row_q;
    logic            row_valid_q;
    logic [RW-1:0]   row_addr_q;
    logic            frame_done_q;

    logic [RW-1:0]   next_row;
    logic            slot_free;

    assign next_row  = (fill_row_q == RW'(NUM_ROW_ADDR-1)) ? '0 : fill_row_q + 1'b1;
    assign slot_free = !row_valid_q || row_ready_in;

    // NOTE: one clocked block with non-blocking assignments; every read below sees the
    // pre-edge value, so later assignments in the block simply take priority.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= IDLE;
            bank_q       <= 1'b0;
            fill_row_q   <= '0;
            col_q        <= '0;
            rd_en_q      <= 1'b0;
            cap_en_q     <= 1'b0;
            cap_col_q    <= '0;
            // NOTE: the row buffers are cleared too, so a row half-built before reset can never leak out.
            fill_q       <= '0;
            row_q        <= '0;
            row_valid_q  <= 1'b0;
            row_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= row_valid_q && row_ready_in && (row_addr_q == RW'(NUM_ROW_ADDR-1));
            if (row_valid_q && row_ready_in)
                row_valid_q <= 1'b0;

            // RAM answers one cycle after the strobe, so capture trails issue by one cycle.
            cap_en_q  <= rd_en_q;
            cap_col_q <= col_q;
            if (cap_en_q) begin
                fill_q.top.r[cap_col_q] <= mem_data_in[0];
                fill_q.top.g[cap_col_q] <= mem_data_in[1];
                fill_q.top.b[cap_col_q] <= mem_data_in[2];
                fill_q.bot.r[cap_col_q] <= mem_data_in[3];
                fill_q.bot.g[cap_col_q] <= mem_data_in[4];
                fill_q.bot.b[cap_col_q] <= mem_data_in[5];
            end

            case (state_q)
                IDLE: begin
                    rd_en_q <= 1'b0;
                    if (enable_in) begin
                        state_q <= FILL;
                        rd_en_q <= 1'b1;
                        col_q   <= '0;
                        if (fill_row_q == '0)
                            bank_q <= bank_sel_in;
                    end
                end
                FILL: begin
                    if (col_q == CW'(NUM_COLS-1)) begin
                        rd_en_q <= 1'b0;
                        state_q <= LAST;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                LAST: state_q <= HOLD;
                HOLD: begin
                    if (slot_free) begin
                        row_q       <= fill_q;
                        row_addr_q  <= fill_row_q;
                        row_valid_q <= 1'b1;
                        fill_row_q  <= next_row;
                        if (enable_in) begin
                            state_q <= FILL;
                            rd_en_q <= 1'b1;
                            col_q   <= '0;
                            // Bank only switches at a frame boundary to avoid tearing.
                            if (next_row == '0)
                                bank_q <= bank_sel_in;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr_out    = {bank_q, fill_row_q, col_q};
    assign mem_rd_en_out   = rd_en_q;
    assign row_out         = row_q;
    assign row_valid_out   = row_valid_q;
    assign row_address_out = row_addr_q;
    assign frame_done_out  = frame_done_q;
endmodule

// File: tb/tb_led_display_frame_reader.sv
// Scoreboard bench for led_display_frame_reader: a behavioural RAM/row model feeds an
// expected-row queue; a negedge monitor pops and compares every accepted row.
module tb_led_display_frame_reader;
    import led_display_pkg::*;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        enable_in = 1'b0;
    logic        bank_sel_in = 1'b0;
    logic [10:0] mem_addr;
    logic        mem_rd_en;
    logic [5:0]  mem_data = '0;
    rgb_row_t    row_out;
    logic        row_valid;
    logic        row_ready = 1'b1;
    logic [3:0]  row_address;
    logic        frame_done;

    always #5 clk = ~clk;

    led_display_frame_reader dut (
        .clk_in          (clk),
        .reset_in        (reset_in),
        .enable_in       (enable_in),
        .bank_sel_in     (bank_sel_in),
        .mem_addr_out    (mem_addr),
        .mem_rd_en_out   (mem_rd_en),
        .mem_data_in     (mem_data),
        .row_out         (row_out),
        .row_valid_out   (row_valid),
        .row_ready_in    (row_ready),
        .row_address_out (row_address),
        .frame_done_out  (frame_done)
    );

    logic [5:0] mem [0:2047];
    always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

    typedef struct {
        logic [3:0] addr;
        rgb_row_t   row;
    } exp_t;

    exp_t     sb_q[$];
    int       tests = 0;
    int       fails = 0;
    int       accepted = 0;
    int       fd_count = 0;
    int       strobes = 0;
    int       m_row = 0;
    int       ready_mode = 0;
    rgb_row_t last_row0;
    rgb_row_t last_row3;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out or unexpected event", name);
    endtask

    function automatic rgb_row_t model_row(input logic bank, input int row);
        rgb_row_t   r;
        logic [5:0] px;
        logic [3:0] rr;
        logic [5:0] cc;
        rr = 4'(row);
        for (int c = 0; c < 64; c++) begin
            cc = 6'(c);
            px = mem[{bank, rr, cc}];
            r.top.r[c] = px[0];
            r.top.g[c] = px[1];
            r.top.b[c] = px[2];
            r.bot.r[c] = px[3];
            r.bot.g[c] = px[4];
            r.bot.b[c] = px[5];
        end
        return r;
    endfunction

    // Expected rows: addresses count 0..15 and wrap; each frame reads one bank.
    task automatic plan_rows(input int n, input logic bank_a, input logic bank_b);
        int   frames;
        logic cur_bank;
        exp_t e;
        frames   = 0;
        cur_bank = bank_a;
        for (int i = 0; i < n; i++) begin
            if (m_row == 0) begin
                cur_bank = (frames == 0) ? bank_a : bank_b;
                frames++;
            end
            e.addr = 4'(m_row);
            e.row  = model_row(cur_bank, m_row);
            sb_q.push_back(e);
            m_row = (m_row + 1) % 16;
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       row_ready = 1'b1;
            1:       row_ready = 1'($urandom_range(0, 1));
            default: row_ready = 1'b0;
        endcase
    end

    logic in_burst = 1'b0;
    logic burst_ok = 1'b1;
    int   burst_len = 0;
    logic prev15 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset_in) begin
            in_burst = 1'b0;
            prev15   = 1'b0;
        end else begin
            if (prev15 || frame_done) check("frame_done", frame_done, prev15);
            if (frame_done) fd_count++;
            prev15 = row_valid && row_ready && (row_address == 4'd15);

            if (row_valid && row_ready) begin
                accepted++;
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_row");
                end else begin
                    e = sb_q.pop_front();
                    check("row_addr", row_address, e.addr);
                    check("row_data", row_out, e.row);
                    if (row_address == 4'd0) last_row0 = row_out;
                    if (row_address == 4'd3) last_row3 = row_out;
                end
            end

            if (mem_rd_en) begin
                strobes++;
                if (!in_burst) begin
                    in_burst  = 1'b1;
                    burst_len = 0;
                    burst_ok  = 1'b1;
                end
                if (mem_addr[5:0] != 6'(burst_len)) burst_ok = 1'b0;
                burst_len++;
            end else if (in_burst) begin
                in_burst = 1'b0;
                check("burst_len", burst_len, 64);
                check("burst_cols_contiguous", burst_ok, 1'b1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic finish_rows(input int target);
        int budget;
        budget = 0;
        while (accepted < target - 1 && budget < 8000) begin
            step(1);
            budget++;
        end
        enable_in = 1'b0;
        while (accepted < target && budget < 8000) begin
            step(1);
            budget++;
        end
        if (budget >= 8000) fail_now("rows_timeout");
        step(5);
        check("rows_accepted", accepted, target);
        check("scoreboard_drained", sb_q.size(), 0);
        check("idle_after_stop", {mem_rd_en, row_valid}, 2'b00);
    endtask

    task automatic wait_strobe(input int row, input int col, input string name);
        int budget;
        budget = 0;
        while (budget < 4000) begin
            step(1);
            budget++;
            if (mem_rd_en && mem_addr[9:6] == 4'(row) && (col < 0 || mem_addr[5:0] == 6'(col)))
                break;
        end
        if (budget >= 4000) fail_now(name);
    endtask

    initial begin
        logic [10:0] a;
        logic [63:0] ones;
        rgb_row_t    snap;
        int          lat, base, fd0, s0;
        logic        stable_ok;

        ones = '1;
        for (int i = 0; i < 2048; i++) begin
            a = 11'(i);
            if (!a[10]) mem[i] = (a[9:6] == 4'd3) ? {3'b000, a[0], 2'b00} : 6'b000_001;
            else        mem[i] = 6'($urandom);
        end

        step(3);
        reset_in = 1'b0;

        // Reset in the middle of a fill
        enable_in = 1'b1;
        step(20);
        reset_in = 1'b1;
        step(3);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_valid", row_valid, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_row_out", row_out, '0);
        check("rst_row_addr", row_address, 4'd0);
        check("rst_mem_addr", mem_addr, 11'd0);
        enable_in = 1'b0;
        reset_in  = 1'b0;
        step(1);
        check("idle_after_reset", mem_rd_en, 1'b0);

        // Solid frame with the column-map row 3, bank 0
        base = accepted;
        plan_rows(16, 1'b0, 1'b0);
        enable_in = 1'b1;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                check("first_strobe", mem_rd_en, 1'b1);
                check("first_addr", mem_addr, 11'd0);
            end
            if (row_valid) begin
                lat = c - 1;
                break;
            end
        end
        check("first_valid_latency", lat, 66);
        finish_rows(base + 16);
        check("row0_top_red", last_row0.top.r, ones);
        check("row0_other_colours", {last_row0.top.g, last_row0.top.b, last_row0.bot}, '0);
        check("row3_top_blue", last_row3.top.b, 64'hAAAA_AAAA_AAAA_AAAA);
        check("row3_other_colours", {last_row3.top.r, last_row3.top.g, last_row3.bot}, '0);

        // Two full frames from bank 1, ready always high
        base = accepted;
        fd0  = fd_count;
        bank_sel_in = 1'b1;
        plan_rows(32, 1'b1, 1'b1);
        enable_in = 1'b1;
        finish_rows(base + 32);
        check("frame_done_pulses", fd_count - fd0, 2);

        // Backpressure while row 5 is presented
        base = accepted;
        plan_rows(16, 1'b1, 1'b1);
        enable_in = 1'b1;
        wait_strobe(5, 10, "wait_row5_fill");
        ready_mode = 2;
        begin
            int budget;
            budget = 0;
            while (!(row_valid && row_address == 4'd5) && budget < 400) begin
                step(1);
                budget++;
            end
            if (budget >= 400) fail_now("wait_row5_valid");
        end
        snap      = row_out;
        s0        = strobes - int'(mem_rd_en);
        stable_ok = 1'b1;
        repeat (199) begin
            step(1);
            if (!(row_valid && row_out == snap && row_address == 4'd5)) stable_ok = 1'b0;
        end
        check("stall_row_stable", stable_ok, 1'b1);
        check("stall_strobes", strobes - s0, 64);
        ready_mode = 0;
        finish_rows(base + 16);

        // Bank swap during row 7 fill, random backpressure
        base = accepted;
        plan_rows(32, 1'b0, 1'b1);
        bank_sel_in = 1'b0;
        ready_mode  = 1;
        enable_in   = 1'b1;
        wait_strobe(7, -1, "wait_row7_fill");
        bank_sel_in = 1'b1;
        wait_strobe(8, -1, "wait_row8_fill");
        check("old_bank_row8", mem_addr[10], 1'b0);
        wait_strobe(0, -1, "wait_next_row0_fill");
        check("new_bank_row0", mem_addr[10], 1'b1);
        finish_rows(base + 32);
        ready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
